i2s_playback_tx: RTL
====================

// Module: i2s_playback_tx
// PURPOSE
//  Downstream stage of the voice/mixer chain: takes one stereo shortint pair per audio frame over a
//  valid/ready handshake and serialises it to the codec as I2S (bclk, pblrc, pbdat), all from mclk.
//  Generates the frame-rate pblrc that upstream voices use as their sample clock, plus a frame_start strobe.
// PARAMETERS
//  SAMPLE_BITS    16   width of each channel sample, signed two's complement
//  SLOT_BITS      32   bclk periods per channel slot (64 bclk per frame)
//  MCLK_PER_BCLK  4    mclk cycles per bclk period (MCLK_PER_BCLK*2*SLOT_BITS = 256 = mclk/fs)
// PORTS
//  mclk          in   1            master clock (256x sample rate); sole clock
//  rst_n         in   1            asynchronous, active-low reset
//  sample_l      in   SAMPLE_BITS  left sample, signed
//  sample_r      in   SAMPLE_BITS  right sample, signed
//  sample_valid  in   1            pair on sample_l/r valid; held stable until accepted
//  sample_ready  out  1            shadow register empty; accept when valid && ready
//  bclk          out  1            bit clock, mclk/4, 50% duty
//  pblrc         out  1            word select: 0 = left slot, 1 = right slot; period 256 mclk
//  pbdat         out  1            serial data, MSB first, I2S one-bclk delay
//  frame_start   out  1            one-mclk pulse when frame counter = 0
//  underrun_cnt  out  16           saturating count of frames with no pair available
// BEHAVIOUR
//  - One clock, async active-low reset. Reset values: cnt=0, bclk=0, pblrc=0, pbdat=0, frame_start=0,
//    sample_ready=1, underrun_cnt=0, shadow empty, shift regs zero. Reset mid-frame discards shadow and
//    current frame; after release frame restarts at cnt=0, left slot, zeros unless new pair loaded.
//  - 8-bit free-running cnt wraps 255->0. bclk = cnt[1]; pblrc = cnt[7]; bit position p = cnt[6:2].
//    bclk falls on cnt[1:0] 3->0; pbdat and pblrc change only there.
//  - Slot content: positions 1..SAMPLE_BITS carry MSB..LSB; position 0 and SAMPLE_BITS+1..31 drive 0.
//  - pbdat registered: updated on cycles with cnt[1:0]==3, so value during bit period p is slot bit p.
//  - Handshake: valid && ready writes shadow {l,r}, ready drops next cycle. Load cycle is cnt==255:
//    shadow full -> copy to shift regs, shadow empties, ready=1 from cnt==0.
//    shadow empty and valid same cycle -> pair bypasses straight into shift regs, no underrun.
//    shadow empty, no valid -> underrun: shift regs load zeros, underrun_cnt += 1 (saturate 16'hFFFF).
//  - Latency: pair loaded at cnt==255 of frame N -> left MSB on pbdat during cnt 4..7 of frame N+1,
//    right MSB during cnt 132..135.
//  - frame_start registered, high exactly for cycle with cnt==0; never during reset.
//  - No back-to-back accept within a frame once shadow full; at most one pair consumed per frame.
// CONFIGURATION
//  I2S_TX_HOLD_ON_UNDERRUN_EN defined: underrun reloads last transmitted pair (repeat) instead of zeros;
//    underrun_cnt still increments; after reset "last pair" is zero.
//  Not defined: underrun transmits zeros (silence).
// STRUCTURE
//  i2s_pkg: SLOT_BITS, MCLK_PER_BCLK, FRAME_MCLKS localparams; typedef struct packed {shortint l, r;}
//    stereo_sample_t; typedef logic [7:0] frame_cnt_t.
//  Sub-module i2s_clkgen: frame counter, bclk/pblrc generation, bit index, load/shift/frame_start strobes.
//  Top holds shadow reg, handshake, shift regs, underrun counter, optional hold logic.
// TESTING
//  1 Release reset, sample_valid=0 for 3 frames -> pbdat always 0, bclk period 4, pblrc period 256, underrun_cnt=3.
//  2 Send L=16'h8001, R=16'h7FFE before cnt 255 -> next frame left pos1..16 = 1000_0000_0000_0001,
//    right = 0111_1111_1111_1110, all other positions 0, underrun_cnt unchanged.
//  3 Hold valid with two queued pairs -> 2nd waits ready=0 until cycle after load (cnt==0), then accepted.
//  4 Shadow empty, assert valid only in cnt==255 cycle with 16'h1234/16'h5678 -> sent next frame, no underrun.
//  5 Assert rst_n=0 at cnt=100 mid-stream -> all outputs zero immediately; after release pblrc=0,
//    frame_start after 1 cycle, first frame zeros, shadow content lost.
//  6 Send 16'h1234/16'h5678 once then stop: with macro -> pair repeats every frame; without -> zeros; both count underruns.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and types for the I2S playback transmitter:
//               frame geometry, stereo sample pair and frame counter types.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

   // Frame geometry: MCLK_PER_BCLK mclk per bit, SLOT_BITS bits per channel.
   localparam int SLOT_BITS     = 32;
   localparam int MCLK_PER_BCLK = 4;
   localparam int FRAME_MCLKS   = MCLK_PER_BCLK * 2 * SLOT_BITS;

   // Frame counter bit fields: [BCLK_LSB-1] is bclk, [POS_LSB +: POS_W] is
   // the bit position inside a slot, [CHAN_BIT] selects left/right.
   localparam int BCLK_LSB = $clog2(MCLK_PER_BCLK);
   localparam int POS_LSB  = BCLK_LSB;
   localparam int POS_W    = $clog2(SLOT_BITS);
   localparam int CHAN_BIT = POS_LSB + POS_W;

   typedef logic [7:0] frame_cnt_t;

   // Last count of a frame; the shift registers are reloaded on this cycle.
   localparam frame_cnt_t LAST_CNT = frame_cnt_t'(FRAME_MCLKS - 1);

   typedef struct packed {
      shortint l;
      shortint r;
   } stereo_sample_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_playback_tx_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_playback_tx_clkgen (i2s_clkgen)
// Description : Free-running frame counter with registered bclk, pblrc and
//               frame_start, plus strobes telling the data path when to load
//               a new pair and when to present the next serial bit.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkgen
   import i2s_pkg::*;
(
   input  logic             mclk,
   input  logic             rst_n,
   output logic             bclk,
   output logic             pblrc,
   output logic             frame_start,
   output logic             load_stb,
   output logic             shift_stb,
   output logic             next_chan,
   output logic [POS_W-1:0] next_pos
);

   logic       run_q, run_d;
   logic [7:0] cnt_q, cnt_d;
   logic       bclk_q, bclk_d;
   logic       pblrc_q, pblrc_d;
   logic       frame_start_q, frame_start_d;

   // Next-state logic: the counter holds at 0 for the first cycle after
   // reset so that frame_start can mark the first frame like every other.
   always_comb begin
      run_d         = 1'b1;
      cnt_d         = run_q ? (cnt_q + 8'd1) : 8'd0;
      bclk_d        = cnt_d[BCLK_LSB-1];
      pblrc_d       = cnt_d[CHAN_BIT];
      frame_start_d = (cnt_d == 8'd0);
   end

   // Counter and clock outputs, all registered so they are glitch-free.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         cnt_q         <= 8'd0;
         bclk_q        <= 1'b0;
         pblrc_q       <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         run_q         <= run_d;
         cnt_q         <= cnt_d;
         bclk_q        <= bclk_d;
         pblrc_q       <= pblrc_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bclk        = bclk_q;
   assign pblrc       = pblrc_q;
   assign frame_start = frame_start_q;

   // Load happens on the last count of a frame; serial data advances on the
   // last mclk of every bit period so pbdat changes together with bclk fall.
   assign load_stb  = (cnt_q == LAST_CNT);
   assign shift_stb = run_q && (cnt_q[BCLK_LSB-1:0] == {BCLK_LSB{1'b1}});
   assign next_pos  = cnt_d[POS_LSB +: POS_W];
   assign next_chan = cnt_d[CHAN_BIT];

endmodule : i2s_clkgen
`default_nettype wire

// File: rtl/i2s_playback_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_playback_tx
// Description : Accepts one stereo pair per frame over valid/ready into a
//               shadow register and serialises it as I2S (MSB first, one bclk
//               delay after the pblrc edge). Counts frames with no pair.
//               Optional macro I2S_TX_HOLD_ON_UNDERRUN_EN: on underrun the
//               last transmitted pair is repeated instead of silence.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_playback_tx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_BITS = 16
)
(
   input  logic                   mclk,
   input  logic                   rst_n,
   input  logic [SAMPLE_BITS-1:0] sample_l,
   input  logic [SAMPLE_BITS-1:0] sample_r,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   output logic                   bclk,
   output logic                   pblrc,
   output logic                   pbdat,
   output logic                   frame_start,
   output logic [15:0]            underrun_cnt
);

   // Slot positions 1..SAMPLE_BITS carry data; everything else is zero.
   localparam logic [POS_W-1:0] POS_FIRST = POS_W'(1);
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(SAMPLE_BITS);

   logic             load_stb;
   logic             shift_stb;
   logic             next_chan;
   logic [POS_W-1:0] next_pos;

   i2s_clkgen u_clkgen (
      .mclk        (mclk),
      .rst_n       (rst_n),
      .bclk        (bclk),
      .pblrc       (pblrc),
      .frame_start (frame_start),
      .load_stb    (load_stb),
      .shift_stb   (shift_stb),
      .next_chan   (next_chan),
      .next_pos    (next_pos)
   );

   stereo_sample_t        shadow_q, shadow_d;
   logic                  shadow_full_q, shadow_full_d;
   logic [SAMPLE_BITS-1:0] sh_l_q, sh_l_d;
   logic [SAMPLE_BITS-1:0] sh_r_q, sh_r_d;
   logic                  pbdat_q, pbdat_d;
   logic [15:0]           underrun_q, underrun_d;
   stereo_sample_t        incoming;
   stereo_sample_t        fill_pair;
   logic                  accept;

   assign incoming = {sample_l, sample_r};
   assign accept   = sample_valid && !shadow_full_q;

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
   stereo_sample_t last_q, last_d;

   // Remember whatever pair was loaded so an underrun can repeat it.
   always_comb begin
      last_d = last_q;
      if (load_stb) begin
         last_d = {sh_l_d, sh_r_d};
      end
   end

   // Last transmitted pair; zero after reset.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
      end else begin
         last_q <= last_d;
      end
   end

   assign fill_pair = last_q;
`else
   assign fill_pair = '0;
`endif

   // Data path: serial shifting, frame-boundary load and shadow handshake.
   always_comb begin
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      sh_l_d        = sh_l_q;
      sh_r_d        = sh_r_q;
      pbdat_d       = pbdat_q;
      underrun_d    = underrun_q;

      if (shift_stb) begin
         if ((next_pos >= POS_FIRST) && (next_pos <= POS_LAST)) begin
            if (next_chan) begin
               pbdat_d = sh_r_q[SAMPLE_BITS-1];
               sh_r_d  = sh_r_q << 1;
            end else begin
               pbdat_d = sh_l_q[SAMPLE_BITS-1];
               sh_l_d  = sh_l_q << 1;
            end
         end else begin
            pbdat_d = 1'b0;
         end
      end

      if (load_stb) begin
         // Shadow wins; otherwise a pair offered this very cycle bypasses
         // the shadow; otherwise the frame is an underrun.
         if (shadow_full_q) begin
            sh_l_d        = shadow_q.l;
            sh_r_d        = shadow_q.r;
            shadow_full_d = 1'b0;
         end else if (sample_valid) begin
            sh_l_d = incoming.l;
            sh_r_d = incoming.r;
         end else begin
            sh_l_d = fill_pair.l;
            sh_r_d = fill_pair.r;
            if (underrun_q != 16'hFFFF) begin
               underrun_d = underrun_q + 16'd1;
            end
         end
      end else if (accept) begin
         shadow_d      = incoming;
         shadow_full_d = 1'b1;
      end
   end

   // Data path registers.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         sh_l_q        <= '0;
         sh_r_q        <= '0;
         pbdat_q       <= 1'b0;
         underrun_q    <= 16'd0;
      end else begin
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         sh_l_q        <= sh_l_d;
         sh_r_q        <= sh_r_d;
         pbdat_q       <= pbdat_d;
         underrun_q    <= underrun_d;
      end
   end

   assign sample_ready = !shadow_full_q;
   assign pbdat        = pbdat_q;
   assign underrun_cnt = underrun_q;

endmodule : i2s_playback_tx
`default_nettype wire
